// File: rtl/wb_ram_responder.sv
// Wishbone classic-cycle slave with an internal 32-bit word RAM.
// A request is latched in IDLE, optionally delayed in WAIT for WAIT_CYCLES
// cycles, and then terminated from RESP. The termination (ack or err plus
// read data) is registered, so it appears in the cycle after RESP.
//
// Handshake: a request is accepted at a rising edge where the FSM is IDLE and
// wb_cyc_i & wb_stb_i are both 1. Exactly one of wb_ack_o / wb_err_o is then
// high for one cycle, WAIT_CYCLES+1 edges after the accepting edge. Dropping
// wb_cyc_i while in WAIT aborts the request silently. The master drops
// wb_stb_i once the request has been accepted; a request still presented in
// IDLE is accepted again.
module wb_ram_responder #(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW     = $clog2(DEPTH);
  // Window bounds in 33 bits so a window ending at 4 GiB does not overflow.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            take;
  logic            resp_fire;

  logic            hit_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     wdat_q;
  logic [AW-1:0]   idx_q;

  logic [32:0]     adr_ext;
  logic [32:0]     offset;
  logic            hit_now;
  logic [AW-1:0]   idx_now;

  logic [31:0]     mem [DEPTH];

  assign dbg_state_o = state_q;

  // Decode the incoming address against the window.
  always_comb begin
    adr_ext = {1'b0, wb_adr_i};
    offset  = adr_ext - WIN_LO;
    hit_now = (adr_ext >= WIN_LO) && (adr_ext < WIN_HI);
    idx_now = AW'(offset >> 2);
  end

  // Next-state logic: accept, count wait states, abort, terminate.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    resp_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          take    = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        resp_fire = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, request latches and registered termination outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hit_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      wdat_q   <= 32'd0;
      idx_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_ack_o <= resp_fire && hit_q;
      wb_err_o <= resp_fire && !hit_q;
      wb_dat_o <= (resp_fire && hit_q && !we_q) ? mem[idx_q] : 32'd0;
      if (take) begin
        hit_q  <= hit_now;
        we_q   <= wb_we_i;
        sel_q  <= wb_sel_i;
        wdat_q <= wb_dat_i;
        idx_q  <= idx_now;
      end
    end
  end

  // Byte-lane RAM write, committed as the request terminates.
  always_ff @(posedge clk_i) begin
    if (resp_fire && hit_q && we_q) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_q[n]) mem[idx_q][8*n +: 8] <= wdat_q[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_responder.sv
// Bench for wb_ram_responder: two instances (no wait states at base 0, and
// three wait states in a small window ending at the top of the address map),
// driven by directed and random Wishbone requests.
module tb_wb_ram_responder;

  localparam int EW = 65; // {is_err, data, response cycle}

  logic        clk;
  logic        rstn;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] adr  [2];
  logic [3:0]  sel  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];
  logic [1:0]  st   [2];

  logic [EW-1:0] exp_q [2][$];
  logic [31:0]   mem_m [2][256];
  int unsigned   cyc_cnt;
  int            chk_cnt;
  int            pass_cnt;

  wb_ram_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]),
    .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .dbg_state_o(st[0])
  );

  wb_ram_responder #(.DEPTH(16), .BASE_ADDR(32'hFFFF_FFC0), .WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]),
    .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .dbg_state_o(st[1])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int wc(int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int dp(int i);
    return (i == 0) ? 256 : 16;
  endfunction

  function automatic logic [31:0] base(int i);
    return (i == 0) ? 32'h0 : 32'hFFFF_FFC0;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every termination pops one expected response.
  task automatic mon(int i);
    logic [EW-1:0] e;
    check($sformatf("u%0d_ack_err_exclusive", i), 64'(ack[i] & err[i]), 64'd0);
    if (ack[i] || err[i]) begin
      check($sformatf("u%0d_resp_expected", i), 64'(exp_q[i].size() != 0), 64'd1);
      if (exp_q[i].size() != 0) begin
        e = exp_q[i].pop_front();
        check($sformatf("u%0d_resp_is_err", i), 64'(err[i]), 64'(e[64]));
        check($sformatf("u%0d_resp_data", i), 64'(rdat[i]), 64'(e[63:32]));
        check($sformatf("u%0d_resp_cycle", i), 64'(cyc_cnt), 64'(e[31:0]));
      end
    end else begin
      check($sformatf("u%0d_idle_dat_zero", i), 64'(rdat[i]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Driver: present a request, predict its response, wait for termination.
  task automatic do_req(int i, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d);
    logic [63:0] a64, b64;
    logic        hit;
    int          idx;
    logic [31:0] rd;
    logic        got;
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; wdat[i] = d;
    @(posedge clk);
    #1;
    a64 = {32'd0, a};
    b64 = {32'd0, base(i)};
    hit = (a64 >= b64) && (a64 < b64 + 64'(dp(i) * 4));
    idx = hit ? int'((a64 - b64) >> 2) : 0;
    rd  = 32'd0;
    if (hit && w) begin
      for (int n = 0; n < 4; n++)
        if (s[n]) mem_m[i][idx][8*n +: 8] = d[8*n +: 8];
    end else if (hit) begin
      rd = mem_m[i][idx];
    end
    exp_q[i].push_back({~hit, rd, cyc_cnt + 32'(wc(i) + 1)});
    stb[i] = 1'b0;
    // Scramble request fields to show only latched values matter.
    we[i] = 1'($urandom); adr[i] = $urandom; sel[i] = 4'($urandom); wdat[i] = $urandom;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ack[i] || err[i]) got = 1'b1;
    end
    check($sformatf("u%0d_resp_arrived", i), 64'(got), 64'd1);
  endtask

  task automatic release_bus(int i);
    @(negedge clk);
    cyc[i] = 1'b0;
  endtask

  task automatic rand_req(int i);
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom;
    else a = base(i) - 32'd8 + 32'($urandom_range(0, dp(i) * 4 + 15));
    do_req(i, 1'($urandom), a, 4'($urandom), $urandom);
    if ($urandom_range(0, 3) == 0) release_bus(i);
  endtask

  initial begin
    logic [31:0] b;
    chk_cnt = 0;
    pass_cnt = 0;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = 32'd0; sel[i] = 4'd0; wdat[i] = 32'd0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_reset_ack", i), 64'(ack[i]), 64'd0);
      check($sformatf("u%0d_reset_err", i), 64'(err[i]), 64'd0);
      check($sformatf("u%0d_reset_dat", i), 64'(rdat[i]), 64'd0);
      check($sformatf("u%0d_reset_state", i), 64'(st[i]), 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Preload every word so the model never has to guess RAM contents.
    for (int k = 0; k < 256; k++) do_req(0, 1'b1, 32'(k * 4), 4'hF, $urandom);
    release_bus(0);
    for (int k = 0; k < 16; k++) do_req(1, 1'b1, base(1) + 32'(k * 4), 4'hF, $urandom);
    release_bus(1);

    // Directed: full write/read, partial write, window edges, sel 0.
    do_req(0, 1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h8, 4'hF, 32'h0);
    do_req(0, 1'b1, 32'h4, 4'hF, 32'h1122_3344);
    do_req(0, 1'b1, 32'h4, 4'b0101, 32'hAABB_CCDD);
    do_req(0, 1'b0, 32'h4, 4'h0, 32'h0);
    check("u0_partial_write_model", 64'(mem_m[0][1]), 64'h11BB_33DD);
    do_req(0, 1'b0, 32'h3FC, 4'hF, 32'h0);
    do_req(0, 1'b1, 32'h400, 4'hF, 32'h5555_AAAA);
    do_req(0, 1'b0, 32'h0, 4'hF, 32'h0);
    do_req(0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF);
    do_req(0, 1'b0, 32'h11, 4'h1, 32'h0);
    release_bus(0);

    // stb without cyc must be ignored.
    @(negedge clk);
    stb[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("u0_stb_without_cyc_state", 64'(st[0]), 64'd0);
    @(negedge clk);
    stb[0] = 1'b0;

    b = base(1);
    do_req(1, 1'b0, b, 4'hF, 32'h0);
    do_req(1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0);
    do_req(1, 1'b1, 32'h0, 4'hF, 32'h1234_5678);
    do_req(1, 1'b0, b - 32'd4, 4'hF, 32'h0);
    do_req(1, 1'b1, b + 32'd4, 4'b1010, 32'hCAFE_F00D);
    do_req(1, 1'b0, b + 32'd4, 4'h0, 32'h0);
    release_bus(1);

    // Abort: cyc dropped during the second wait cycle.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = b + 32'd8;
    sel[1] = 4'hF; wdat[1] = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    stb[1] = 1'b0;
    check("u3_abort_in_wait", 64'(st[1]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0;
    @(posedge clk);
    #1;
    check("u3_abort_state_idle", 64'(st[1]), 64'd0);
    do_req(1, 1'b1, b + 32'd20, 4'hF, 32'h7777_1111);
    do_req(1, 1'b0, b + 32'd8, 4'hF, 32'h0);
    release_bus(1);
    repeat (6) @(posedge clk);

    // Reset in the middle of a pending write.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = b + 32'd12;
    sel[1] = 4'hF; wdat[1] = 32'hFEED_FACE;
    @(posedge clk);
    #1;
    stb[1] = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_midreset_ack", i), 64'(ack[i]), 64'd0);
      check($sformatf("u%0d_midreset_err", i), 64'(err[i]), 64'd0);
      check($sformatf("u%0d_midreset_dat", i), 64'(rdat[i]), 64'd0);
      check($sformatf("u%0d_midreset_state", i), 64'(st[i]), 64'd0);
    end
    cyc[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("u3_after_reset_state", 64'(st[1]), 64'd0);
    do_req(1, 1'b0, b + 32'd12, 4'hF, 32'h0);
    release_bus(1);

    // Random traffic against the reference model.
    for (int k = 0; k < 200; k++) rand_req(0);
    release_bus(0);
    for (int k = 0; k < 150; k++) rand_req(1);
    release_bus(1);

    repeat (10) @(posedge clk);
    #1;
    check("u0_queue_drained", 64'(exp_q[0].size()), 64'd0);
    check("u3_queue_drained", 64'(exp_q[1].size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
